// File: rtl/ixc_ofifo_pack_pkg.sv
// Shared types and default sizes for the output-FIFO packer (ixc_ofifo_pack).
package ixc_ofifo_pkg;

    localparam int LANE_W_DEF = 64;
    localparam int LANES_DEF  = 8;
    localparam int ACK_W_DEF  = 18;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        ACK
    } stateT;

    typedef logic [511:0]  beatT;
    typedef logic [1023:0] accT;

endpackage

// File: rtl/ixc_ofifo_pack_if.sv
// Stream-in / beat-out bundle for ixc_ofifo_pack; outPar exists only with IXC_OFIFO_PARITY_EN.
interface ixc_ofifo_pack_if
    import ixc_ofifo_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int ACK_W  = ACK_W_DEF
);
    localparam int BEAT_W = LANES * LANE_W;
    localparam int LEN_W  = $clog2(LANES) + 1;

    logic [BEAT_W-1:0] oData;
    logic              oDataEn;
    logic [LEN_W-1:0]  oDataLen;
    logic              flush;
    logic              inReady;
    logic [BEAT_W-1:0] outData;
    logic              outValid;
    logic              outReady;
    logic              ackClk;
    logic [ACK_W-1:0]  ackLen;
    logic              lenErr;
`ifdef IXC_OFIFO_PARITY_EN
    logic [LANES-1:0]  outPar;
`endif

    modport master (
        output oData, oDataEn, oDataLen, flush, outReady,
`ifdef IXC_OFIFO_PARITY_EN
        input  outPar,
`endif
        input  inReady, outData, outValid, ackClk, ackLen, lenErr
    );

    modport slave (
        input  oData, oDataEn, oDataLen, flush, outReady,
`ifdef IXC_OFIFO_PARITY_EN
        output outPar,
`endif
        output inReady, outData, outValid, ackClk, ackLen, lenErr
    );

endinterface

// File: rtl/ixc_ofifo_pack_lane_insert.sv
// Places a 1..LANES-lane word at a lane offset inside a 2*LANES-lane vector and builds its lane mask.
module ixc_lane_insert #(
    parameter int LANE_W = 64,
    parameter int LANES  = 8
) (
    input  logic [LANES*LANE_W-1:0]   word,
    input  logic [$clog2(LANES):0]    len,
    input  logic [$clog2(2*LANES):0]  offset,
    output logic [2*LANES*LANE_W-1:0] placed,
    output logic [2*LANES-1:0]        mask
);
    localparam int ACC_LANES = 2 * LANES;
    localparam int ACC_W     = ACC_LANES * LANE_W;

    always_comb begin
        placed = ACC_W'(word) << (offset * LANE_W);
        mask   = ACC_LANES'((32'd1 << len) - 32'd1) << offset;
    end

endmodule

// File: rtl/ixc_ofifo_pack.sv
// Packs variable-length lane words into dense beats, pads on flush and acks per packet.
// Optional: define IXC_OFIFO_PARITY_EN to add per-lane even parity on outPar.
module ixc_ofifo_pack
    import ixc_ofifo_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int ACK_W  = ACK_W_DEF
) (
    input logic            fclk,
    input logic            reset,
    ixc_ofifo_pack_if.slave bus
);
    localparam int BEAT_W    = LANES * LANE_W;
    localparam int ACC_LANES = 2 * LANES;
    localparam int ACC_W     = ACC_LANES * LANE_W;
    localparam int FILL_W    = $clog2(ACC_LANES) + 1;

    stateT              state;
    logic [ACC_W-1:0]   acc;
    logic [FILL_W-1:0]  fill;
    logic [ACK_W-1:0]   wordCnt;
    logic               ackClkQ;
    logic [ACK_W-1:0]   ackLenQ;
    logic               lenErrQ;

    logic               inReady;
    logic               outValid;
    logic               lenOk;
    logic               accept;
    logic               pop;
    logic [FILL_W-1:0]  fillPop;
    logic [FILL_W-1:0]  fillNext;
    logic [ACC_W-1:0]   accPop;
    logic [ACC_W-1:0]   accNext;
    logic [ACC_W-1:0]   placed;
    logic [ACC_LANES-1:0] mask;

    assign inReady  = !reset && (state == RUN) && (fill <= FILL_W'(LANES));
    assign outValid = ((state == RUN) && (fill >= FILL_W'(LANES))) ||
                      ((state == FLUSH) && (fill != '0));
    assign lenOk    = (bus.oDataLen != '0) && (bus.oDataLen <= ($bits(bus.oDataLen))'(LANES));
    assign accept   = bus.oDataEn && inReady && lenOk;
    assign pop      = outValid && bus.outReady;

    // A pop retires the head beat before the new word lands, so same-cycle push/pop packs densely.
    assign fillPop  = !pop ? fill :
                      (fill >= FILL_W'(LANES)) ? fill - FILL_W'(LANES) : '0;
    assign accPop   = pop ? (acc >> BEAT_W) : acc;
    assign fillNext = accept ? fillPop + FILL_W'(bus.oDataLen) : fillPop;

    ixc_lane_insert #(
        .LANE_W (LANE_W),
        .LANES  (LANES)
    ) u_insert (
        .word   (bus.oData),
        .len    (bus.oDataLen),
        .offset (fillPop),
        .placed (placed),
        .mask   (mask)
    );

    always_comb begin
        // NOTE: default first so every path assigns accNext and no latch is inferred.
        accNext = accPop;
        for (int i = 0; i < ACC_LANES; i++) begin
            if (accept && mask[i]) begin
                accNext[i*LANE_W +: LANE_W] = placed[i*LANE_W +: LANE_W];
            end
        end
    end

    // Lanes at or above fill are zeroed, which both pads the flush beat and hides stale lanes.
    always_comb begin
        bus.outData = '0;
`ifdef IXC_OFIFO_PARITY_EN
        bus.outPar  = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
            if (FILL_W'(i) < fill) begin
                bus.outData[i*LANE_W +: LANE_W] = acc[i*LANE_W +: LANE_W];
            end
`ifdef IXC_OFIFO_PARITY_EN
            bus.outPar[i] = ^bus.outData[i*LANE_W +: LANE_W];
`endif
        end
    end

    always_ff @(posedge fclk) begin
        if (reset) begin
            // NOTE: the accumulator is reset too, so a packet cut by reset leaves no lanes behind.
            state   <= RUN;
            acc     <= '0;
            fill    <= '0;
            wordCnt <= '0;
            ackClkQ <= 1'b0;
            ackLenQ <= '0;
            lenErrQ <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register samples the pre-edge values.
            acc  <= accNext;
            fill <= fillNext;
            if (bus.oDataEn && inReady && !lenOk) begin
                lenErrQ <= 1'b1;
            end
            if (pop && (wordCnt != {ACK_W{1'b1}})) begin
                wordCnt <= wordCnt + 1'b1;
            end
            case (state)
                RUN: begin
                    if (bus.flush && inReady) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (fill == '0) begin
                        state <= ACK;
                    end
                end
                ACK: begin
                    ackLenQ <= wordCnt;
                    ackClkQ <= ~ackClkQ;
                    wordCnt <= '0;
                    state   <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.inReady  = inReady;
    assign bus.outValid = outValid;
    assign bus.ackClk   = ackClkQ;
    assign bus.ackLen   = ackLenQ;
    assign bus.lenErr   = lenErrQ;

endmodule

// File: tb/tb_ixc_ofifo_pack.sv
// Directed bench for ixc_ofifo_pack: beat packing, back-pressure, flush/ack, length errors, reset.
module tb_ixc_ofifo_pack;
    import ixc_ofifo_pkg::*;

    logic fclk;
    logic reset;
    int   nCompared;
    int   nMismatched;

    ixc_ofifo_pack_if bus ();

    ixc_ofifo_pack dut (
        .fclk  (fclk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        fclk = 1'b0;
        forever #5 fclk = ~fclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] ln(input logic [7:0] tag, input int i);
        return {tag, 48'h0, 8'(i)};
    endfunction

    function automatic beatT mkWord(input logic [7:0] tag);
        beatT w;
        for (int i = 0; i < 8; i++) w[i*64 +: 64] = ln(tag, i);
        return w;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge fclk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] len, input beatT data, input logic fl);
        bus.oDataEn  = en;
        bus.oDataLen = len;
        bus.oData    = data;
        bus.flush    = fl;
    endtask

    beatT wA, wB, w0, w1, w2, wC, wD, wE, wF, wG, expBeat;
    logic [7:0] expPar;

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        wA = mkWord(8'hA0); wB = mkWord(8'hB0);
        w0 = mkWord(8'h10); w1 = mkWord(8'h11); w2 = mkWord(8'h12);
        wC = mkWord(8'hC0); wD = mkWord(8'hD0);
        wE = mkWord(8'hE0); wF = mkWord(8'hF0); wG = mkWord(8'h60);
        expPar = '0;

        // Reset
        reset = 1'b1;
        bus.outReady = 1'b0;
        drive(1'b0, 4'd0, '0, 1'b0);
        step();
        check("rst_inReady", 512'(bus.inReady), 512'd0);
        check("rst_outValid", 512'(bus.outValid), 512'd0);
        check("rst_ackClk", 512'(bus.ackClk), 512'd0);
        check("rst_ackLen", 512'(bus.ackLen), 512'd0);
        check("rst_lenErr", 512'(bus.lenErr), 512'd0);
        reset = 1'b0;
        step();
        check("post_rst_inReady", 512'(bus.inReady), 512'd1);

        // Two full words back to back, then flush
        bus.outReady = 1'b1;
        drive(1'b1, 4'd8, wA, 1'b0);
        step();
        check("t1_valid_a", 512'(bus.outValid), 512'd1);
        check("t1_beat_a", bus.outData, wA);
        drive(1'b1, 4'd8, wB, 1'b0);
        step();
        check("t1_valid_b", 512'(bus.outValid), 512'd1);
        check("t1_beat_b", bus.outData, wB);
        drive(1'b0, 4'd0, '0, 1'b1);
        step();
        check("t1_flush_inReady", 512'(bus.inReady), 512'd0);
        check("t1_flush_valid", 512'(bus.outValid), 512'd0);
        drive(1'b0, 4'd0, '0, 1'b0);
        step();
        check("t1_ackClk_hold", 512'(bus.ackClk), 512'd0);
        step();
        check("t1_ackClk", 512'(bus.ackClk), 512'd1);
        check("t1_ackLen", 512'(bus.ackLen), 512'd2);

        // Three 3-lane words, then padded flush
        drive(1'b1, 4'd3, w0, 1'b0);
        step();
        check("t2_valid_3", 512'(bus.outValid), 512'd0);
        drive(1'b1, 4'd3, w1, 1'b0);
        step();
        drive(1'b1, 4'd3, w2, 1'b0);
        step();
        drive(1'b0, 4'd0, '0, 1'b0);
        expBeat = '0;
        for (int i = 0; i < 3; i++) begin
            expBeat[i*64 +: 64]     = ln(8'h10, i);
            expBeat[(i+3)*64 +: 64] = ln(8'h11, i);
        end
        expBeat[6*64 +: 64] = ln(8'h12, 0);
        expBeat[7*64 +: 64] = ln(8'h12, 1);
        check("t2_valid_9", 512'(bus.outValid), 512'd1);
        check("t2_inReady_9", 512'(bus.inReady), 512'd0);
        check("t2_beat1", bus.outData, expBeat);
        step();
        check("t2_valid_1", 512'(bus.outValid), 512'd0);
        check("t2_inReady_1", 512'(bus.inReady), 512'd1);
        drive(1'b0, 4'd0, '0, 1'b1);
        step();
        drive(1'b0, 4'd0, '0, 1'b0);
        expBeat = '0;
        expBeat[63:0] = ln(8'h12, 2);
        check("t2_pad_valid", 512'(bus.outValid), 512'd1);
        check("t2_beat2", bus.outData, expBeat);
        step();
        check("t2_drained", 512'(bus.outValid), 512'd0);
        step();
        step();
        check("t2_ackClk", 512'(bus.ackClk), 512'd0);
        check("t2_ackLen", 512'(bus.ackLen), 512'd2);

        // Back-pressure with a full accumulator
        bus.outReady = 1'b0;
        drive(1'b1, 4'd8, wC, 1'b0);
        step();
        check("t3_inReady_8", 512'(bus.inReady), 512'd1);
        drive(1'b1, 4'd8, wD, 1'b0);
        step();
        drive(1'b0, 4'd0, '0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check("t3_stall_inReady", 512'(bus.inReady), 512'd0);
            check("t3_stall_valid", 512'(bus.outValid), 512'd1);
            check("t3_stall_data", bus.outData, wC);
            step();
        end
        bus.outReady = 1'b1;
        step();
        check("t3_rel_data", bus.outData, wD);
        check("t3_rel_inReady", 512'(bus.inReady), 512'd1);
        step();
        check("t3_empty", 512'(bus.outValid), 512'd0);
        drive(1'b0, 4'd0, '0, 1'b1);
        step();
        drive(1'b0, 4'd0, '0, 1'b0);
        step();
        step();
        check("t3_ackClk", 512'(bus.ackClk), 512'd1);
        check("t3_ackLen", 512'(bus.ackLen), 512'd2);

        // Illegal lengths are dropped and latch lenErr
        drive(1'b1, 4'd3, wE, 1'b0);
        step();
        drive(1'b1, 4'd0, wA, 1'b0);
        step();
        check("t5_lenErr_0", 512'(bus.lenErr), 512'd1);
        drive(1'b1, 4'd12, wB, 1'b0);
        step();
        check("t5_lenErr_12", 512'(bus.lenErr), 512'd1);
        check("t5_valid", 512'(bus.outValid), 512'd0);
        drive(1'b1, 4'd5, wF, 1'b0);
        step();
        drive(1'b0, 4'd0, '0, 1'b0);
        expBeat = '0;
        for (int i = 0; i < 3; i++) expBeat[i*64 +: 64] = ln(8'hE0, i);
        for (int i = 0; i < 5; i++) expBeat[(i+3)*64 +: 64] = ln(8'hF0, i);
        check("t5_valid_8", 512'(bus.outValid), 512'd1);
        check("t5_beat", bus.outData, expBeat);
        step();
        check("t5_drained", 512'(bus.outValid), 512'd0);
        check("t5_lenErr_sticky", 512'(bus.lenErr), 512'd1);

        // Reset while flushing a partial beat
        bus.outReady = 1'b0;
        drive(1'b1, 4'd5, wG, 1'b0);
        step();
        drive(1'b0, 4'd0, '0, 1'b1);
        step();
        drive(1'b0, 4'd0, '0, 1'b0);
        expBeat = '0;
        for (int i = 0; i < 5; i++) expBeat[i*64 +: 64] = ln(8'h60, i);
        check("t6_valid", 512'(bus.outValid), 512'd1);
        check("t6_pad_beat", bus.outData, expBeat);
`ifdef IXC_OFIFO_PARITY_EN
        for (int i = 0; i < 8; i++) expPar[i] = ^expBeat[i*64 +: 64];
        check("t6_parity", 512'(bus.outPar), 512'(expPar));
`endif
        reset = 1'b1;
        step();
        check("t6_rst_valid", 512'(bus.outValid), 512'd0);
        check("t6_rst_ackClk", 512'(bus.ackClk), 512'd0);
        check("t6_rst_ackLen", 512'(bus.ackLen), 512'd0);
        check("t6_rst_lenErr", 512'(bus.lenErr), 512'd0);
        check("t6_rst_inReady", 512'(bus.inReady), 512'd0);
        reset = 1'b0;
        step();
        check("t6_inReady", 512'(bus.inReady), 512'd1);
        step();
        step();
        check("t6_no_ack", 512'(bus.ackClk), 512'd0);
        check("t6_no_valid", 512'(bus.outValid), 512'd0);

        // Flush with an empty accumulator
        bus.outReady = 1'b1;
        drive(1'b0, 4'd0, '0, 1'b1);
        step();
        drive(1'b0, 4'd0, '0, 1'b0);
        check("t4_flush_valid", 512'(bus.outValid), 512'd0);
        check("t4_flush_inReady", 512'(bus.inReady), 512'd0);
        step();
        check("t4_ack_valid", 512'(bus.outValid), 512'd0);
        step();
        check("t4_ackClk", 512'(bus.ackClk), 512'd1);
        check("t4_ackLen", 512'(bus.ackLen), 512'd0);
        check("t4_back_in_run", 512'(bus.inReady), 512'd1);
        step();
        check("t4_ackClk_hold", 512'(bus.ackClk), 512'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/ixc_ofifo_pack.md
Name: ixc_ofifo_pack

Overview:
- Downstream stage of the input-FIFO block.
- Consumes its variable-length output stream (oData/oDataEn/oDataLen, in 64-bit lanes) and packs it into dense 512-bit beats for the host-bound output FIFO, using a valid/ready handshake.
- On each packet flush, pads the final partial beat and reports completion with a toggle-style ackClk and a word count on ackLen.

Parameters:
- LANE_W, 64, width of one lane in bits
- LANES, 8, lanes per output beat (beat = LANES*LANE_W = 512 bits)
- ACK_W, 18, width of ackLen

Ports:
- fclk  input  1  fast clock; sole clock
- reset  input  1  synchronous, active-high reset
- oData  input  512  lane-packed input; lane 0 = bits [63:0]
- oDataEn  input  1  input word valid
- oDataLen  input  4  valid lanes in oData, legal 1..8, taken from lane 0 upward
- flush  input  1  end-of-packet pulse; may coincide with oDataEn
- inReady  output  1  block accepts oDataEn/flush this cycle
- outData  output  512  packed beat
- outValid  output  1  outData valid
- outReady  input  1  downstream accepts beat
- ackClk  output  1  toggles once per completed packet
- ackLen  output  18  beats emitted in the last completed packet
- lenErr  output  1  sticky; illegal oDataLen seen

Behaviour:
- Clocking and reset: one clock, fclk. Reset is synchronous and active-high.
- Reset values: accumulator 0, fill 0, wordCnt 0, state RUN, inReady 0 during reset, outValid 0, ackClk 0, ackLen 0, lenErr 0.
- Reset mid-packet discards all buffered lanes. No ack is produced for the discarded packet.
- Storage: a 1024-bit accumulator (16 lanes) and a 5-bit fill count (0..16).
- States: RUN, FLUSH, ACK.
- inReady = (state==RUN) && (fill <= LANES). Combinational from registers only; no dependence on outReady.
- Accept: oDataEn && inReady && 1<=oDataLen<=8.
  - Accepted lanes are written at lane index fill', where fill' = fill - (pop ? LANES : 0).
  - New fill = fill' + oDataLen.
  - Push and pop in the same cycle are legal.
- Illegal oDataLen (0 or 9..15) with oDataEn && inReady: word dropped, lenErr set until reset.
- RUN: outValid = fill >= LANES. outData = lanes 0..7.
- Pop: outValid && outReady. Shifts the accumulator down 8 lanes and increments wordCnt.
- wordCnt saturates at 2^ACK_W-1.
- flush && inReady in RUN: any same-cycle data is appended first, then state goes to FLUSH.
- FLUSH:
  - inReady = 0.
  - outValid = fill > 0.
  - If fill < 8, lanes at index >= fill are driven to zero (padded beat); a pop then sets fill to 0.
  - When fill == 0 (registered), go to ACK.
- ACK (exactly one cycle): ackLen <= wordCnt, ackClk <= ~ackClk, wordCnt <= 0, then RUN.
- Flush with empty accumulator: FLUSH lasts one cycle, then ACK with ackLen = 0.
- ackClk/ackLen change only in ACK and hold otherwise.
- Latency: an accepted word completing a beat makes outValid high on the next cycle.
- Throughput: one beat per cycle when input is 8 lanes/cycle and outReady is held high.
- outData/outValid must stay stable while outValid && !outReady.

Optional Feature:
- IXC_OFIFO_PARITY_EN defined: adds output outPar[7:0], even parity per 64-bit lane of outData. Padded lanes give parity 0. outPar is valid with outValid.
- Macro undefined: port and logic absent, with identical behaviour otherwise.

Decomposition:
- Package ixc_ofifo_pkg holds:
  - LANE_W, LANES and ACK_W defaults
  - the state enum {RUN, FLUSH, ACK}
  - the beat typedef (logic [511:0])
  - the accumulator typedef (logic [1023:0])
- One sub-module, ixc_lane_insert: combinational. Places a 1..8-lane word at lane offset 0..8 in a 16-lane vector and generates the matching lane mask.

Test Plan:
- Reset, then oDataLen=8 words A,B with outReady=1 -> beats A,B on consecutive cycles. Flush -> ackClk 0->1, ackLen=2.
- Words of len 3,3,3 then flush -> beat 1 = lanes w0[0..2],w1[0..2],w2[0..1]. Beat 2 = w2[2] with lanes 1..7 zero. ackLen=2.
- outReady=0 for 5 cycles with fill=16 -> inReady=0, outData stable. Release -> two beats, inReady returns.
- Flush with empty accumulator -> ackLen=0, ackClk toggles once, no outValid.
- oDataLen=0 and oDataLen=12 -> words dropped, lenErr=1 and sticky, fill unchanged.
- reset asserted in FLUSH with fill=5 -> next cycle outValid=0, ackClk and ackLen=0, no ack toggle.
